// File: rtl/fmap_pkg.sv
// Shared types for the feature-map memory streamers (writer now, reader later).
package fmap_pkg;

  localparam int unsigned FMAP_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fmap_wr_state_t;

endpackage

// File: rtl/fmap_writer.sv
// Snapshots a packed feature map on start and streams it word by word into a memory write port.
// Optional checksum output enabled by defining FMAP_WRITER_CSUM_EN.
module fmap_writer
  import fmap_pkg::*;
#(
  parameter int unsigned MAP_WIDTH = 3,
  parameter int unsigned DATA_W    = FMAP_DATA_W,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [MAP_WIDTH*MAP_WIDTH*DATA_W-1:0]  in_map,
  output logic                                   busy,
  output logic                                   done,
  output logic [ADDR_W-1:0]                      mem_addr,
  output logic [DATA_W-1:0]                      mem_wdata,
  output logic                                   mem_we,
  input  logic                                   mem_ready
`ifdef FMAP_WRITER_CSUM_EN
  ,
  output logic [DATA_W-1:0]                      csum
`endif
);

  localparam int unsigned N        = MAP_WIDTH * MAP_WIDTH;
  localparam int unsigned MAP_BITS = N * DATA_W;
  localparam int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SEL_W    = (MAP_BITS > 1) ? $clog2(MAP_BITS) : 1;

  fmap_wr_state_t          state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d, idx_inc;
  logic [MAP_BITS-1:0]     snap_q, snap_d;
  logic [ADDR_W-1:0]       addr_d;
  logic [DATA_W-1:0]       wdata_d, next_word;
  logic [SEL_W-1:0]        sel_base;
  logic                    we_d, done_d, busy_d;
`ifdef FMAP_WRITER_CSUM_EN
  logic [DATA_W-1:0]       csum_d;
`endif

  assign idx_inc   = idx_q + IDX_W'(1);
  assign sel_base  = SEL_W'(idx_inc) * SEL_W'(DATA_W);
  assign next_word = snap_q[sel_base +: DATA_W];

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    we_d    = 1'b0;
    done_d  = 1'b0;
`ifdef FMAP_WRITER_CSUM_EN
    csum_d  = csum;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          snap_d  = in_map;
          idx_d   = '0;
          we_d    = 1'b1;
          addr_d  = ADDR_W'(BASE_ADDR);
          wdata_d = in_map[DATA_W-1:0];
`ifdef FMAP_WRITER_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      WRITE: begin
        we_d = 1'b1;
        if (mem_ready) begin
`ifdef FMAP_WRITER_CSUM_EN
          csum_d = csum + mem_wdata;
`endif
          if (idx_q == IDX_W'(N - 1)) begin
            state_d = DONE;
            we_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_inc;
            addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_inc);
            wdata_d = next_word;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, snapshot and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      snap_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
`ifdef FMAP_WRITER_CSUM_EN
      csum      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_we    <= we_d;
      done      <= done_d;
      busy      <= busy_d;
`ifdef FMAP_WRITER_CSUM_EN
      csum      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_fmap_writer.sv
// Randomized self-checking bench for fmap_writer against a word-list memory model.
module tb_fmap_writer;

  localparam int unsigned MAP_WIDTH = 3;
  localparam int unsigned N         = MAP_WIDTH * MAP_WIDTH;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned BASE_ADDR = 0;
  localparam int unsigned MAP_BITS  = N * DATA_W;
  localparam int          BUDGET    = 200;

  logic                clk;
  logic                reset;
  logic                start;
  logic [MAP_BITS-1:0] in_map;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_we;
  logic                mem_ready;
`ifdef FMAP_WRITER_CSUM_EN
  logic [DATA_W-1:0]   csum;
`endif

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] words [N];

  fmap_writer #(
    .MAP_WIDTH(MAP_WIDTH),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_map   (in_map),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_ready(mem_ready)
`ifdef FMAP_WRITER_CSUM_EN
    ,
    .csum     (csum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout global watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MAP_BITS-1:0] pack_words();
    logic [MAP_BITS-1:0] p;
    p = '0;
    for (int k = N - 1; k >= 0; k--) p = (p << DATA_W) | MAP_BITS'(words[k]);
    return p;
  endfunction

  function automatic logic [DATA_W-1:0] model_sum();
    logic [DATA_W-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s = s + words[k];
    return s;
  endfunction

  function automatic logic [MAP_BITS-1:0] junk_map();
    logic [MAP_BITS-1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p = (p << DATA_W) | MAP_BITS'($urandom);
    return p;
  endfunction

  // mode 0: ready always high; 1: random ready plus stray start pulses; 2: two stall cycles on word 4.
  task automatic run_pass(input int mode);
    int cyc, k, stalls;
    bit seen, prev_stall;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pdata, exp_word;
    in_map    = pack_words();
    start     = 1'b1;
    mem_ready = 1'b1;
    step();
    start  = 1'b0;
    in_map = {N{DATA_W'(7)}};
    cyc = 1; k = 0; stalls = 0; seen = 1'b0; prev_stall = 1'b0;
    paddr = '0; pdata = '0;
    while (cyc < BUDGET) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      check("busy_write", 64'(busy), 64'(1));
      check("we_write", 64'(mem_we), 64'(1));
      if (prev_stall) begin
        check("hold_addr", 64'(mem_addr), 64'(paddr));
        check("hold_data", 64'(mem_wdata), 64'(pdata));
      end
      case (mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = ($urandom_range(0, 2) != 0);
        default: mem_ready = !(k == 4 && stalls < 2);
      endcase
      if (mode == 1) begin
        start  = ($urandom_range(0, 3) == 0);
        in_map = junk_map();
      end
      if (mem_ready) begin
        exp_word = (k < int'(N)) ? words[k] : '0;
        check("addr", 64'(mem_addr), 64'(BASE_ADDR + k));
        check("data", 64'(mem_wdata), 64'(exp_word));
        k++;
        prev_stall = 1'b0;
      end else begin
        stalls++;
        prev_stall = 1'b1;
        paddr = mem_addr;
        pdata = mem_wdata;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 64'(seen), 64'(1));
    check("done_cycle", 64'(cyc), 64'(N + 1 + stalls));
    check("accepts", 64'(k), 64'(N));
    check("busy_done", 64'(busy), 64'(1));
    check("we_done", 64'(mem_we), 64'(0));
`ifdef FMAP_WRITER_CSUM_EN
    check("csum", 64'(csum), 64'(model_sum()));
`endif
    // A start during the done cycle must not launch another pass.
    start  = 1'b1;
    in_map = junk_map();
    step();
    start = 1'b0;
    check("busy_after", 64'(busy), 64'(0));
    check("done_pulse", 64'(done), 64'(0));
    check("we_after", 64'(mem_we), 64'(0));
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    mem_ready = 1'b0;
    in_map    = '0;
    step();
    step();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_we", 64'(mem_we), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    reset = 1'b1;
    step();

    for (int k = 0; k < N; k++) words[k] = DATA_W'(k + 1);
    run_pass(0);
    run_pass(2);
    run_pass(1);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) words[k] = $urandom;
      run_pass(1);
    end

    // Reset in the middle of a pass, then a fresh pass must restart at word 0.
    for (int k = 0; k < N; k++) words[k] = DATA_W'(k + 1);
    in_map    = pack_words();
    start     = 1'b1;
    mem_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("pre_rst_addr", 64'(mem_addr), 64'(BASE_ADDR + 5));
    check("pre_rst_data", 64'(mem_wdata), 64'(6));
    reset = 1'b0;
    #1;
    check("mid_rst_we", 64'(mem_we), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_addr", 64'(mem_addr), 64'(0));
    step();
    reset = 1'b1;
    step();
    for (int k = 0; k < N; k++) words[k] = $urandom;
    run_pass(0);

    for (int k = 0; k < N; k++) words[k] = '1;
    run_pass(0);
    for (int k = 0; k < N; k++) words[k] = (k % 2 == 0) ? DATA_W'(-3) : DATA_W'(3);
    run_pass(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
